// File: rtl/vga_pattern_scheduler.sv
// vga_pattern_scheduler
// Frame-synchronous controller for the VGA pattern datapath. It picks the
// active pattern generator, steps the color-rotation index every
// FRAMES_PER_STEP frames, and takes debounced "next" and "pause" buttons.
// Every visible change is applied only on a frame_tick, so a frame is never
// split between two settings.
module vga_pattern_scheduler #(
    parameter int FRAMES_PER_STEP = 60,
    parameter int NUM_PATTERNS    = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           btn_next,
    input  logic           btn_pause,
    output logic [1:0]     pattern_sel,
    output logic [1:0]     color_rotate,
    output logic           paused,
    output logic           pending,
    output logic [FCW-1:0] frame_cnt
);

    // Debounce counter width: it must hold DEBOUNCE_CYCLES-1.
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_STEP - 1);
    localparam logic [1:0]     PAT_LAST   = 2'(NUM_PATTERNS - 1);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    // Bit 0 is the "next" button, bit 1 the "pause" button.
    logic [1:0] btn_raw;
    logic [1:0] btn_evt;

    assign btn_raw = {btn_pause, btn_next};

    // One synchronizer + debouncer + rising-edge detector per button.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic           sync1_reg;
        logic           sync2_reg;
        logic           deb_reg;
        logic           evt_reg;
        logic [DCW-1:0] cnt_reg;

        // Two-flop synchronizer for the asynchronous button input.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
            end else begin
                sync1_reg <= btn_raw[gi];
                sync2_reg <= sync1_reg;
            end
        end

        // Accept a new level only after it has differed from the debounced
        // level for DEBOUNCE_CYCLES consecutive cycles; emit a one-cycle
        // event only when the accepted level is a press (0->1).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
                deb_reg <= 1'b0;
                evt_reg <= 1'b0;
            end else begin
                evt_reg <= 1'b0;
                if (sync2_reg == deb_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_LAST) begin
                    cnt_reg <= '0;
                    deb_reg <= sync2_reg;
                    evt_reg <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign btn_evt[gi] = evt_reg;
    end

    state_t         state_reg,        state_next;
    logic [1:0]     pattern_sel_reg,  pattern_sel_next;
    logic [1:0]     color_rotate_reg, color_rotate_next;
    logic [FCW-1:0] frame_cnt_reg,    frame_cnt_next;
    logic           next_pending_reg, next_pending_next;
    logic           pause_pending_reg, pause_pending_next;
    state_t         state_eff;

    // State and output registers; everything visible changes only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= RUN;
            pattern_sel_reg   <= '0;
            color_rotate_reg  <= '0;
            frame_cnt_reg     <= '0;
            next_pending_reg  <= 1'b0;
            pause_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pattern_sel_reg   <= pattern_sel_next;
            color_rotate_reg  <= color_rotate_next;
            frame_cnt_reg     <= frame_cnt_next;
            next_pending_reg  <= next_pending_next;
            pause_pending_reg <= pause_pending_next;
        end
    end

    // Frame-boundary scheduler: apply pause first (its new state governs this
    // tick), then next-pattern, which overrides the rotation step.
    always_comb begin
        state_next         = state_reg;
        pattern_sel_next   = pattern_sel_reg;
        color_rotate_next  = color_rotate_reg;
        frame_cnt_next     = frame_cnt_reg;
        state_eff          = state_reg;

        if (frame_tick) begin
            if (pause_pending_reg) begin
                state_eff = (state_reg == RUN) ? PAUSED : RUN;
            end
            state_next = state_eff;

            if (next_pending_reg) begin
                pattern_sel_next  = (pattern_sel_reg == PAT_LAST) ? 2'd0
                                                                  : pattern_sel_reg + 2'd1;
                color_rotate_next = 2'd0;
                frame_cnt_next    = '0;
            end else if (state_eff == RUN) begin
                if (frame_cnt_reg == FRAME_LAST) begin
                    frame_cnt_next    = '0;
                    color_rotate_next = color_rotate_reg + 2'd1;
                end else begin
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                end
            end
        end

        // Flags are consumed by a tick using their old values; an event on the
        // same cycle re-arms its flag for the following tick.
        next_pending_next  = btn_evt[0] ? 1'b1 : (frame_tick ? 1'b0 : next_pending_reg);
        pause_pending_next = (frame_tick ? 1'b0 : pause_pending_reg) ^ btn_evt[1];
    end

    assign pattern_sel  = pattern_sel_reg;
    assign color_rotate = color_rotate_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign paused       = (state_reg == PAUSED);
    assign pending      = next_pending_reg | pause_pending_reg;

endmodule
